// File: rtl/itu656_pkg.sv
// Shared types and constants for the BT.656 decoder: FSM encodings, TRS bytes,
// XY bit positions and the XY protection-bit function.
package itu656_pkg;

    typedef enum logic [1:0] {
        TRS_HUNT,
        TRS_T1,
        TRS_T2,
        TRS_T3
    } trs_state_t;

    typedef enum logic [2:0] {
        PIX_IDLE,
        PIX_CB,
        PIX_Y0,
        PIX_CR,
        PIX_Y1
    } pix_state_t;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int XY_ONE = 7;
    localparam int XY_F   = 6;
    localparam int XY_V   = 5;
    localparam int XY_H   = 4;

    // Wide enough to count past any sane line length so the length check stays exact.
    localparam int PAIR_CNT_W = 11;
    localparam int X_MAX      = 511;

    function automatic logic [3:0] prot_bits(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/itu656_trs_detect.sv
// Timing-reference (FF 00 00 XY) matcher. Optional XY protection checking is
// compiled in with ITU656_PROT_CHECK_EN.
module itu656_trs_detect
    import itu656_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    output logic       trs_hit,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       prot_fail
);

    trs_state_t state_reg;
    trs_state_t state_next;
    logic       xy_ok;

    assign f = in_data[XY_F];
    assign v = in_data[XY_V];
    assign h = in_data[XY_H];

`ifdef ITU656_PROT_CHECK_EN
    assign xy_ok     = in_data[XY_ONE] && (in_data[3:0] == prot_bits(f, v, h));
    assign prot_fail = (state_reg == TRS_T3) && in_data[XY_ONE] && !xy_ok;
`else
    assign xy_ok     = in_data[XY_ONE];
    assign prot_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= TRS_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // A stray FF always restarts the preamble rather than dropping to HUNT.
    always_comb begin
        state_next = TRS_HUNT;
        trs_hit    = 1'b0;
        case (state_reg)
            TRS_HUNT: begin
                if (in_data == TRS_FF) state_next = TRS_T1;
            end
            TRS_T1: begin
                if (in_data == TRS_00)      state_next = TRS_T2;
                else if (in_data == TRS_FF) state_next = TRS_T1;
            end
            TRS_T2: begin
                if (in_data == TRS_00)      state_next = TRS_T3;
                else if (in_data == TRS_FF) state_next = TRS_T1;
            end
            TRS_T3: begin
                if (xy_ok)                  trs_hit    = 1'b1;
                else if (in_data == TRS_FF) state_next = TRS_T1;
            end
            default: state_next = TRS_HUNT;
        endcase
    end

endmodule

// File: rtl/itu656_decoder.sv
// BT.656 byte-stream decoder: locks on a vertical-blanking EAV, then emits
// Cb-Y-Cr-Y pairs with position, field and line-length status. Optional
// protection-bit checking is enabled with ITU656_PROT_CHECK_EN.
module itu656_decoder
    import itu656_pkg::*;
#(
    parameter int PAIRS_PER_LINE = 360,
    parameter int LINE_W         = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    output logic [7:0]        out_cb,
    output logic [7:0]        out_y0,
    output logic [7:0]        out_cr,
    output logic [7:0]        out_y1,
    output logic              out_sof,
    output logic              out_eol,
    output logic [8:0]        out_x,
    output logic [LINE_W-1:0] out_line,
    output logic              out_field,
    output logic              locked,
    output logic              len_err,
    output logic              prot_err
);

    logic trs_hit;
    logic trs_f;
    logic trs_v;
    logic trs_h;
    logic prot_fail;

    itu656_trs_detect u_trs_detect (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .trs_hit   (trs_hit),
        .f         (trs_f),
        .v         (trs_v),
        .h         (trs_h),
        .prot_fail (prot_fail)
    );

    pix_state_t            pix_state_reg;
    pix_state_t            pix_state_next;
    logic                  cap_cb;
    logic                  cap_y0;
    logic                  cap_cr;
    logic                  emit;
    logic                  sav_active;
    logic                  eav_hit;
    logic [7:0]            cb_reg;
    logic [7:0]            y0_reg;
    logic [7:0]            cr_reg;
    logic [PAIR_CNT_W-1:0] pair_cnt_reg;
    logic [8:0]            x_sat;
    logic                  line_active_reg;
    logic                  need_clear_reg;
    logic                  sof_pending_reg;

    assign sav_active = trs_hit && !trs_h && !trs_v && locked;
    assign eav_hit    = trs_hit && trs_h;
    assign x_sat      = (pair_cnt_reg > PAIR_CNT_W'(X_MAX)) ? 9'(X_MAX) : pair_cnt_reg[8:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_state_reg <= PIX_IDLE;
        end else begin
            pix_state_reg <= pix_state_next;
        end
    end

    // Any FF while collecting a pair is the start of a TRS; the partial pair is dropped.
    always_comb begin
        pix_state_next = pix_state_reg;
        cap_cb         = 1'b0;
        cap_y0         = 1'b0;
        cap_cr         = 1'b0;
        emit           = 1'b0;
        if (trs_hit) begin
            pix_state_next = sav_active ? PIX_CB : PIX_IDLE;
        end else if (in_data == TRS_FF) begin
            pix_state_next = PIX_IDLE;
        end else begin
            case (pix_state_reg)
                PIX_CB: begin
                    cap_cb         = 1'b1;
                    pix_state_next = PIX_Y0;
                end
                PIX_Y0: begin
                    cap_y0         = 1'b1;
                    pix_state_next = PIX_CR;
                end
                PIX_CR: begin
                    cap_cr         = 1'b1;
                    pix_state_next = PIX_Y1;
                end
                PIX_Y1: begin
                    emit           = 1'b1;
                    pix_state_next = PIX_CB;
                end
                default: pix_state_next = PIX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cb_reg <= '0;
            y0_reg <= '0;
            cr_reg <= '0;
        end else begin
            if (cap_cb) cb_reg <= in_data;
            if (cap_y0) y0_reg <= in_data;
            if (cap_cr) cr_reg <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid       <= 1'b0;
            out_cb          <= '0;
            out_y0          <= '0;
            out_cr          <= '0;
            out_y1          <= '0;
            out_sof         <= 1'b0;
            out_eol         <= 1'b0;
            out_x           <= '0;
            out_line        <= '0;
            out_field       <= 1'b0;
            locked          <= 1'b0;
            len_err         <= 1'b0;
            pair_cnt_reg    <= '0;
            line_active_reg <= 1'b0;
            need_clear_reg  <= 1'b0;
            sof_pending_reg <= 1'b0;
        end else begin
            out_valid <= emit;
            out_sof   <= emit && sof_pending_reg;
            out_eol   <= 1'b0;

            if (emit) begin
                out_cb          <= cb_reg;
                out_y0          <= y0_reg;
                out_cr          <= cr_reg;
                out_y1          <= in_data;
                out_x           <= x_sat;
                sof_pending_reg <= 1'b0;
                if (pair_cnt_reg != '1) pair_cnt_reg <= pair_cnt_reg + 1'b1;
            end

            if (trs_hit) begin
                out_field <= trs_f;
                // Any blanking code arms the line-counter clear for the next active SAV.
                if (trs_v) need_clear_reg <= 1'b1;
            end

            if (eav_hit) begin
                if (trs_v) locked <= 1'b1;
                if (line_active_reg) begin
                    line_active_reg <= 1'b0;
                    out_eol         <= 1'b1;
                    if (pair_cnt_reg != PAIR_CNT_W'(PAIRS_PER_LINE)) len_err <= 1'b1;
                    if (out_line != '1) out_line <= out_line + 1'b1;
                end
            end

            if (sav_active) begin
                line_active_reg <= 1'b1;
                pair_cnt_reg    <= '0;
                out_x           <= '0;
                if (need_clear_reg) begin
                    out_line        <= '0;
                    need_clear_reg  <= 1'b0;
                    sof_pending_reg <= 1'b1;
                end
            end
        end
    end

`ifdef ITU656_PROT_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prot_err <= 1'b0;
        end else if (prot_fail) begin
            prot_err <= 1'b1;
        end
    end
`else
    logic unused_prot_fail;
    assign unused_prot_fail = prot_fail;
    assign prot_err         = 1'b0;
`endif

endmodule
